alu_acc_seq: RTL and testbench
==============================

Name: alu_acc_seq

Overview:
Parametrised successor to the board-level 4-bit combinational ALU: a WIDTH-bit ALU with a registered 2*WIDTH result/accumulator, a valid/ready input handshake and a multi-cycle shift-add multiplier. It sits between switch/key input logic and the hex/LED display decoders, which read the registered result. Single-cycle ops complete in one clock; multiply takes WIDTH cycles with back-pressure.

Parameters:
WIDTH, 4, operand width in bits; result width is 2*WIDTH; legal range 2..16.

Ports:
clock  input  1  system clock, all state updates on rising edge
resetn  input  1  synchronous active-low reset
in_valid  input  1  operand/op presented this cycle
in_ready  output  1  block can accept an op this cycle
op  input  3  operation select (see Behaviour)
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  one-cycle pulse: result/flags updated
result  output  2*WIDTH  registered result / accumulator
cout  output  1  carry/borrow flag of the last op
zero  output  1  high when result == 0
busy  output  1  high while multiply in progress

Behaviour:
- Reset (resetn==0 at a clock edge): result=0, cout=0, zero=1, out_valid=0, in_ready=1, busy=0, state=IDLE; overrides everything, including an in-flight multiply, which is abandoned.
- Accept = in_valid && in_ready at a rising edge; inputs sampled only then. in_valid while in_ready==0 is ignored (not queued).
- States: IDLE (in_ready=1), MUL (in_ready=0, busy=1). IDLE->MUL on accept with op==6; MUL->IDLE after WIDTH iteration edges.
- Single-cycle ops (op!=6): result/cout/zero update at the accepting edge; out_valid high for exactly the following cycle. Back-to-back accepts every cycle are legal; out_valid stays high continuously.
- op encodings, all results zero-extended to 2*WIDTH unless stated:
  0 ADD: result = a+b (WIDTH+1 bits); cout = carry out of bit WIDTH-1.
  1 SUB: result low WIDTH = (a-b) mod 2^WIDTH, upper bits 0; cout=1 iff a<b (borrow).
  2 ORXOR: result = {a|b, a^b}; cout=0.
  3 AND: result = a&b; cout=0.
  4 ANY: result = 1 if (a|b)!=0 else 0; cout=0.
  5 CAT: result = {a,b}; cout=0.
  6 MUL: result = a*b (unsigned, exact in 2*WIDTH); cout=0.
  7 ACC: result = (result + zero-extended a) mod 2^(2*WIDTH); cout = carry out of bit 2*WIDTH-1. b ignored.
- MUL timing: accept at edge k; internal multiplicand/multiplier/partial product registers iterate at edges k+1..k+WIDTH (one bit of b per edge, LSB first); result, cout, zero update at edge k+WIDTH; out_valid high in cycle after edge k+WIDTH; in_ready high again in that same cycle. result holds its previous value during MUL.
- zero always reflects the registered result (recomputed with every update).
- result/flags hold between ops indefinitely; out_valid never asserts without an accept.

Decomposition:
- Shared package alu_pkg: op encodings (OP_ADD..OP_ACC), state enum (IDLE, MUL).
- One sub-module: rca_n, WIDTH-parametrised ripple-carry adder (a, b, cin -> sum, cout) built from full-adder cells; instantiated for ADD/SUB (b inverted, cin=1) and at 2*WIDTH for ACC and multiplier partial-sum accumulation.

Test Plan:
- WIDTH=4, reset, accept ADD a=F b=1 -> next cycle out_valid=1, result=8'h10, cout=1, zero=0; following cycle out_valid=0, result held.
- SUB a=3 b=5 -> result=8'h0E, cout=1; SUB a=5 b=5 -> result=8'h00, cout=0, zero=1.
- MUL a=F b=F -> in_ready=0, busy=1 for 4 cycles; in_valid with ADD during that time ignored; out_valid one cycle later with result=8'hE1, cout=0; in_ready=1 same cycle.
- CAT a=F b=F (result=8'hFF), then ACC a=1 -> result=8'h00, cout=1, zero=1; ACC a=9 three times -> 09, 12, 1B.
- ORXOR a=6 b=3 -> result=8'h75; ANY a=0 b=0 -> 8'h00, zero=1; back-to-back accepts on consecutive cycles -> out_valid high continuously, results in order.
- Start MUL a=7 b=7, assert resetn=0 at 2nd iteration edge -> next cycle result=0, zero=1, busy=0, in_ready=1, no out_valid pulse; WIDTH=8 rerun MUL a=FF b=FF -> result=16'hFE01 after 8 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator ALU.
// Contents: op_e (operation select encodings), state_e (IDLE / MUL control states).
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_ORXOR = 3'd2,
    OP_AND   = 3'd3,
    OP_ANY   = 3'd4,
    OP_CAT   = 3'd5,
    OP_MUL   = 3'd6,
    OP_ACC   = 3'd7
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_acc_seq_if.sv
// Operand/result bundle between the input logic and the ALU.
// master: drives in_valid, op, a, b; observes in_ready, out_valid, result, cout, zero, busy.
// slave : the ALU side (directions mirrored).
interface alu_acc_seq_if #(
  parameter int unsigned WIDTH = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic [2*WIDTH-1:0]   result;
  logic                 cout;
  logic                 zero;
  logic                 busy;

  modport master (
    output in_valid, op, a, b,
    input  in_ready, out_valid, result, cout, zero, busy
  );

  modport slave (
    input  in_valid, op, a, b,
    output in_ready, out_valid, result, cout, zero, busy
  );
endinterface

// File: rtl/alu_acc_seq_rca.sv
// rca_n: N-bit ripple-carry adder made of full-adder cells.
// Ports: i_a, i_b (N-bit addends), i_cin (carry in), o_sum (N-bit sum), o_cout (carry out).
module rca_n #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_sum,
  output logic         o_cout
);

  logic [N:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cout = w_c[N];

endmodule

// File: rtl/alu_acc_seq.sv
// alu_acc_seq: WIDTH-bit ALU with a registered 2*WIDTH result/accumulator,
// valid/ready input handshake and a WIDTH-cycle shift-add multiplier.
// Ports: clock (rising edge), resetn (synchronous, active low),
//        bus (slave side of alu_acc_seq_if: op/operands in, result/flags out).
module alu_acc_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic          clock,
  input  logic          resetn,
  alu_acc_seq_if.slave  bus
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  state_e           r_state;
  logic [W2-1:0]    r_result;
  logic             r_cout;
  logic             r_out_valid;
  logic [W2-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [W2-1:0]    r_prod;
  logic [CW-1:0]    r_cnt;

  op_e              w_op;
  logic             w_accept;
  logic             w_is_sub;
  logic [WIDTH-1:0] w_as_b;
  logic [WIDTH-1:0] w_as_sum;
  logic             w_as_c;
  logic [W2-1:0]    w_acc_x;
  logic [W2-1:0]    w_acc_y;
  logic [W2-1:0]    w_acc_sum;
  logic             w_acc_c;
  logic [W2-1:0]    w_res;
  logic             w_c;

  assign w_op     = op_e'(bus.op);
  assign w_accept = bus.in_valid && (r_state == IDLE);

  // Subtract as a + ~b + 1; the adder carry is the inverse of the borrow.
  assign w_is_sub = (w_op == OP_SUB);
  assign w_as_b   = w_is_sub ? ~bus.b : bus.b;

  rca_n #(.N(WIDTH)) u_addsub (
    .i_a    (bus.a),
    .i_b    (w_as_b),
    .i_cin  (w_is_sub),
    .o_sum  (w_as_sum),
    .o_cout (w_as_c)
  );

  // Wide adder is shared: accumulator add while idle, partial-product add while multiplying.
  always_comb begin
    w_acc_x = r_result;
    w_acc_y = {{WIDTH{1'b0}}, bus.a};
    if (r_state == MUL) begin
      w_acc_x = r_prod;
      w_acc_y = r_mplier[0] ? r_mcand : '0;
    end
  end

  rca_n #(.N(W2)) u_acc (
    .i_a    (w_acc_x),
    .i_b    (w_acc_y),
    .i_cin  (1'b0),
    .o_sum  (w_acc_sum),
    .o_cout (w_acc_c)
  );

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_res[WIDTH:0] = {w_as_c, w_as_sum};
        w_c            = w_as_c;
      end
      OP_SUB: begin
        w_res[WIDTH-1:0] = w_as_sum;
        w_c              = ~w_as_c;
      end
      OP_ORXOR: w_res = {bus.a | bus.b, bus.a ^ bus.b};
      OP_AND:   w_res[WIDTH-1:0] = bus.a & bus.b;
      OP_ANY:   w_res[0] = |(bus.a | bus.b);
      OP_CAT:   w_res = {bus.a, bus.b};
      OP_ACC: begin
        w_res = w_acc_sum;
        w_c   = w_acc_c;
      end
      default: begin
        w_res = '0;
        w_c   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_result    <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_prod      <= '0;
      r_cnt       <= '0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_op == OP_MUL) begin
              r_state  <= MUL;
              r_mcand  <= W2'(bus.a);
              r_mplier <= bus.b;
              r_prod   <= '0;
              r_cnt    <= '0;
            end else begin
              r_result    <= w_res;
              r_cout      <= w_c;
              r_out_valid <= 1'b1;
            end
          end
        end
        MUL: begin
          r_prod   <= w_acc_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_result    <= w_acc_sum;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.busy      = (r_state == MUL);
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.cout      = r_cout;
  assign bus.zero      = (r_result == '0);

endmodule

// File: tb/tb_alu_acc_seq.sv
// Self-checking bench for alu_acc_seq: WIDTH=4 instance checked every cycle
// against a behavioural model plus directed literal checks; WIDTH=8 instance
// exercised with one long multiply.
module tb_alu_acc_seq;

  localparam int unsigned W = 4;

  logic clock;
  logic resetn;

  int total = 0;
  int bad   = 0;

  alu_acc_seq_if #(.WIDTH(4)) bus4 ();
  alu_acc_seq_if #(.WIDTH(8)) bus8 ();

  alu_acc_seq #(.WIDTH(4)) u_dut4 (.clock(clock), .resetn(resetn), .bus(bus4));
  alu_acc_seq #(.WIDTH(8)) u_dut8 (.clock(clock), .resetn(resetn), .bus(bus8));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the 4-bit instance
  logic [7:0]  m_res;
  logic        m_cout;
  logic        m_ov;
  int unsigned m_cnt;
  logic [7:0]  m_pend;
  bit          chk_en = 1'b0;

  function automatic void calc(input int unsigned op, input longint unsigned ai,
                               input longint unsigned bi, input longint unsigned cur,
                               output longint unsigned r, output bit c);
    c = 1'b0;
    case (op)
      0: begin r = ai + bi; c = (r >= (1 << W)); end
      1: begin r = (ai - bi) % (1 << W); c = (ai < bi); end
      2: r = ((ai | bi) << W) | (ai ^ bi);
      3: r = ai & bi;
      4: r = ((ai | bi) != 0) ? 1 : 0;
      5: r = (ai << W) | bi;
      7: begin r = cur + ai; c = (r >= (1 << (2*W))); r = r % (1 << (2*W)); end
      default: r = ai * bi;
    endcase
  endfunction

  always @(posedge clock) begin : p_model
    longint unsigned r;
    bit c;
    if (!resetn) begin
      m_res  <= '0;
      m_cout <= 1'b0;
      m_ov   <= 1'b0;
      m_cnt  <= 0;
      chk_en <= 1'b1;
    end else begin
      m_ov <= 1'b0;
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_res  <= m_pend;
          m_cout <= 1'b0;
          m_ov   <= 1'b1;
        end
      end else if (bus4.in_valid) begin
        calc(int'(bus4.op), longint'(bus4.a), longint'(bus4.b), longint'(m_res), r, c);
        if (bus4.op == 3'd6) begin
          m_cnt  <= W;
          m_pend <= 8'(r);
        end else begin
          m_res  <= 8'(r);
          m_cout <= c;
          m_ov   <= 1'b1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("cmp_in_ready",  bus4.in_ready,  (m_cnt == 0));
      chk("cmp_busy",      bus4.busy,      (m_cnt != 0));
      chk("cmp_out_valid", bus4.out_valid, m_ov);
      chk("cmp_result",    bus4.result,    m_res);
      chk("cmp_cout",      bus4.cout,      m_cout);
      chk("cmp_zero",      bus4.zero,      (m_res == 0));
    end
  end

  // Called 2ns after a rising edge; presents one op for the next edge and
  // checks the registered outcome against hand-computed literals.
  task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic [7:0] er, input logic ec);
    bus4.in_valid = 1'b1;
    bus4.op = op;
    bus4.a  = a;
    bus4.b  = b;
    @(posedge clock);
    #2;
    bus4.in_valid = 1'b0;
    chk("lit_out_valid", bus4.out_valid, 1'b1);
    chk("lit_result",    bus4.result,    er);
    chk("lit_cout",      bus4.cout,      ec);
    chk("lit_zero",      bus4.zero,      (er == 8'h00));
    chk("lit_model",     m_res,          er);
  endtask

  task automatic idle_chk(input logic [7:0] er);
    @(posedge clock);
    #2;
    chk("idle_out_valid", bus4.out_valid, 1'b0);
    chk("idle_result",    bus4.result,    er);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    resetn = 1'b0;
    bus4.in_valid = 1'b0; bus4.op = '0; bus4.a = '0; bus4.b = '0;
    bus8.in_valid = 1'b0; bus8.op = '0; bus8.a = '0; bus8.b = '0;
    repeat (2) @(posedge clock);
    #2;
    chk("rst_result",    bus4.result,    8'h00);
    chk("rst_zero",      bus4.zero,      1'b1);
    chk("rst_cout",      bus4.cout,      1'b0);
    chk("rst_out_valid", bus4.out_valid, 1'b0);
    chk("rst_in_ready",  bus4.in_ready,  1'b1);
    chk("rst_busy",      bus4.busy,      1'b0);
    resetn = 1'b1;

    send(3'd0, 4'hF, 4'h1, 8'h10, 1'b1);
    idle_chk(8'h10);
    send(3'd1, 4'h3, 4'h5, 8'h0E, 1'b1);
    send(3'd1, 4'h5, 4'h5, 8'h00, 1'b0);
    idle_chk(8'h00);

    // Multiply F*F with ignored ADD requests while busy
    bus4.in_valid = 1'b1; bus4.op = 3'd6; bus4.a = 4'hF; bus4.b = 4'hF;
    @(posedge clock);
    #2;
    for (int i = 0; i < 4; i++) begin
      chk("mul_busy",     bus4.busy,      1'b1);
      chk("mul_in_ready", bus4.in_ready,  1'b0);
      chk("mul_no_ov",    bus4.out_valid, 1'b0);
      chk("mul_hold",     bus4.result,    8'h00);
      bus4.in_valid = 1'b1; bus4.op = 3'd0; bus4.a = 4'h1; bus4.b = 4'h1;
      @(posedge clock);
      #2;
    end
    bus4.in_valid = 1'b0;
    chk("mul_out_valid", bus4.out_valid, 1'b1);
    chk("mul_result",    bus4.result,    8'hE1);
    chk("mul_cout",      bus4.cout,      1'b0);
    chk("mul_in_ready",  bus4.in_ready,  1'b1);
    chk("mul_busy_done", bus4.busy,      1'b0);
    idle_chk(8'hE1);

    // Back-to-back accepts: out_valid stays high, results in order
    send(3'd5, 4'hF, 4'hF, 8'hFF, 1'b0);
    send(3'd7, 4'h1, 4'h0, 8'h00, 1'b1);
    send(3'd7, 4'h9, 4'h3, 8'h09, 1'b0);
    send(3'd7, 4'h9, 4'h0, 8'h12, 1'b0);
    send(3'd7, 4'h9, 4'hF, 8'h1B, 1'b0);
    send(3'd2, 4'h6, 4'h3, 8'h75, 1'b0);
    send(3'd4, 4'h0, 4'h0, 8'h00, 1'b0);
    send(3'd4, 4'h0, 4'h4, 8'h01, 1'b0);
    send(3'd3, 4'hC, 4'hA, 8'h08, 1'b0);
    send(3'd0, 4'h2, 4'h3, 8'h05, 1'b0);
    idle_chk(8'h05);

    // Reset during a multiply abandons it
    bus4.in_valid = 1'b1; bus4.op = 3'd6; bus4.a = 4'h7; bus4.b = 4'h7;
    @(posedge clock);
    #2;
    bus4.in_valid = 1'b0;
    @(posedge clock);
    #2;
    resetn = 1'b0;
    @(posedge clock);
    #2;
    resetn = 1'b1;
    chk("abort_result",    bus4.result,    8'h00);
    chk("abort_zero",      bus4.zero,      1'b1);
    chk("abort_busy",      bus4.busy,      1'b0);
    chk("abort_in_ready",  bus4.in_ready,  1'b1);
    chk("abort_out_valid", bus4.out_valid, 1'b0);
    repeat (6) idle_chk(8'h00);

    // WIDTH=8 multiply
    bus8.in_valid = 1'b1; bus8.op = 3'd6; bus8.a = 8'hFF; bus8.b = 8'hFF;
    @(posedge clock);
    #2;
    bus8.in_valid = 1'b0;
    chk("w8_busy",     bus8.busy,     1'b1);
    chk("w8_in_ready", bus8.in_ready, 1'b0);
    n = 0;
    while (!bus8.out_valid && n < 20) begin
      @(posedge clock);
      #2;
      n++;
    end
    chk("w8_cycles",   n,             8);
    chk("w8_result",   bus8.result,   16'hFE01);
    chk("w8_cout",     bus8.cout,     1'b0);
    chk("w8_zero",     bus8.zero,     1'b0);
    chk("w8_in_ready", bus8.in_ready, 1'b1);

    @(negedge clock);
    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
